// File: rtl/fletcher_checksum_correct_if.sv
// Word-stream bus into the Fletcher accumulator: qualified input word and the live checksum.
interface fletcher_checksum_correct_if #(
  parameter int unsigned Width = 32
);
  logic                 en;
  logic [Width/2-1:0]   din;
  logic [Width-1:0]     dout;

  modport master (output en, output din, input dout);
  modport slave  (input en, input din, output dout);
endinterface

// File: rtl/fletcher_checksum_correct.sv
// Two-stage Fletcher-Width accumulator with true modulo (2^(Width/2)-1) arithmetic.
// dout = {sum2, sum1}; a word enabled at edge k shows up in dout after edge k+1.
module fletcher_checksum_correct #(
  parameter int unsigned Width  = 32,
  parameter bit          SwapIn = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  fletcher_checksum_correct_if.slave bus
);

  localparam int unsigned Half  = Width / 2;
  localparam int unsigned Bytes = Half / 8;
  localparam logic [Half:0] ModulusWide = {1'b0, {Half{1'b1}}};

  if ((Width % 2) != 0) begin : gWidthCheck
    $error("fletcher_checksum_correct: Width must be even");
  end
  if (SwapIn && ((Half % 8) != 0)) begin : gSwapCheck
    $error("fletcher_checksum_correct: SwapIn needs Width/2 to be a multiple of 8");
  end

  logic [Half-1:0] dinOrdered;
  logic            stgEn;
  logic [Half-1:0] stgData;
  logic [Half-1:0] sum1;
  logic [Half-1:0] sum2;
  logic [Half:0]   s1Wide;
  logic [Half:0]   s2Wide;

  // Optional byte reversal, byte 0 being bits [7:0].
  if (SwapIn) begin : gSwap
    always_comb begin
      dinOrdered = '0;
      for (int i = 0; i < int'(Bytes); i++) begin
        dinOrdered[8*i +: 8] = bus.din[8*(int'(Bytes)-1-i) +: 8];
      end
    end
  end else begin : gNoSwap
    assign dinOrdered = bus.din;
  end

  // Both operands are at most M, so one conditional subtraction lands in 0..M-1.
  always_comb begin
    s1Wide = {1'b0, sum1} + {1'b0, stgData};
    if (s1Wide >= ModulusWide) begin
      s1Wide = s1Wide - ModulusWide;
    end
    s2Wide = {1'b0, sum2} + s1Wide;
    if (s2Wide >= ModulusWide) begin
      s2Wide = s2Wide - ModulusWide;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stgEn   <= 1'b0;
      stgData <= '0;
      sum1    <= '0;
      sum2    <= '0;
    end else begin
      stgEn   <= bus.en;
      stgData <= dinOrdered;
      if (stgEn) begin
        sum1 <= s1Wide[Half-1:0];
        sum2 <= s2Wide[Half-1:0];
      end
    end
  end

  assign bus.dout = {sum2, sum1};

endmodule

// File: tb/tb_fletcher_checksum_correct.sv
// Self-checking bench: three configurations (W32, W32 swapped, W16) fed in lockstep,
// checked against known vectors and a modulo-arithmetic reference model.
module tb_fletcher_checksum_correct;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fletcher_checksum_correct_if #(.Width(32)) ifA ();
  fletcher_checksum_correct_if #(.Width(32)) ifB ();
  fletcher_checksum_correct_if #(.Width(16)) ifC ();

  fletcher_checksum_correct #(.Width(32), .SwapIn(1'b0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  fletcher_checksum_correct #(.Width(32), .SwapIn(1'b1)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  fletcher_checksum_correct #(.Width(16), .SwapIn(1'b0)) dutC (.clk(clk), .rst(rst), .bus(ifC));

  typedef struct {
    string            name;
    int unsigned      n;
    logic [2:0][15:0] w;
    int unsigned      reps;
    int unsigned      gap;
    logic [31:0]      exp;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] words[$];

  // Fletcher sums straight from the definition: running sums taken modulo M.
  function automatic logic [31:0] refSum(input logic [15:0] ws[$], input int unsigned half);
    longint unsigned m;
    longint unsigned a;
    longint unsigned b;
    m = (64'd1 << half) - 64'd1;
    a = 0;
    b = 0;
    foreach (ws[i]) begin
      a = (a + (longint'(ws[i]) & m)) % m;
      b = (b + a) % m;
    end
    return 32'((b << half) | a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One clock: inputs applied after a falling edge, outputs readable at the next falling edge.
  task automatic drive(input logic e, input logic [15:0] w);
    ifA.en  = e;
    ifA.din = w;
    ifB.en  = e;
    ifB.din = {w[7:0], w[15:8]};
    ifC.en  = e;
    ifC.din = w[7:0];
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(1'b0, 16'h0);
    rst = 1'b0;
    words.delete();
  endtask

  task automatic setVec(input int idx, input string name, input int unsigned n,
                        input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input int unsigned reps, input int unsigned gap, input logic [31:0] exp);
    vecs[idx].name = name;
    vecs[idx].n    = n;
    vecs[idx].w    = {w2, w1, w0};
    vecs[idx].reps = reps;
    vecs[idx].gap  = gap;
    vecs[idx].exp  = exp;
  endtask

  function automatic logic [15:0] randWord();
    case ($urandom_range(0, 9))
      0:       return 16'hFFFF;
      1:       return 16'hFFFE;
      2:       return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    setVec(0, "abc_b2b",    3, 16'h6261, 16'h6463, 16'h0065, 1,   0, 32'hF04FC729);
    setVec(1, "abc_gaps",   3, 16'h6261, 16'h6463, 16'h0065, 1,   2, 32'hF04FC729);
    setVec(2, "ones_x100",  1, 16'hFFFF, 16'h0,    16'h0,    100, 0, 32'h00000000);
    setVec(3, "fffe_single",1, 16'hFFFE, 16'h0,    16'h0,    1,   0, 32'hFFFEFFFE);
    setVec(4, "zero_single",1, 16'h0000, 16'h0,    16'h0,    1,   0, 32'h00000000);
    setVec(5, "one_x3",     1, 16'h0001, 16'h0,    16'h0,    3,   1, 32'h00060003);

    ifA.en = 1'b0; ifA.din = '0;
    ifB.en = 1'b0; ifB.din = '0;
    ifC.en = 1'b0; ifC.din = '0;
    @(negedge clk);

    doReset();
    drive(1'b0, 16'h0);
    check("reset_A", ifA.dout, 32'h0);
    check("reset_B", ifB.dout, 32'h0);
    check("reset_C", {16'h0, ifC.dout}, 32'h0);

    // Table vectors; B receives byte-swapped words and must land on the same result.
    for (int v = 0; v < 6; v++) begin
      doReset();
      for (int r = 0; r < int'(vecs[v].reps); r++) begin
        for (int k = 0; k < int'(vecs[v].n); k++) begin
          drive(1'b1, vecs[v].w[k]);
          for (int g = 0; g < int'(vecs[v].gap); g++) drive(1'b0, 16'hDEAD);
        end
      end
      drive(1'b0, 16'h0);
      check({vecs[v].name, "_A"}, ifA.dout, vecs[v].exp);
      check({vecs[v].name, "_B"}, ifB.dout, vecs[v].exp);
    end

    // Sampling before the flush clock shows only the first two words.
    doReset();
    drive(1'b1, 16'h6261);
    drive(1'b1, 16'h6463);
    drive(1'b1, 16'h0065);
    check("partial_A", ifA.dout, 32'h2926C6C4);
    drive(1'b0, 16'h0);
    check("flushed_A", ifA.dout, 32'hF04FC729);
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h1234);
    check("hold_A", ifA.dout, 32'hF04FC729);

    // Fletcher-16 over bytes a..e.
    doReset();
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h61 + i));
    drive(1'b0, 16'h0);
    check("f16_abcde_C", {16'h0, ifC.dout}, 32'h0000C8F0);

    // Reset mid-stream, including a word in flight and one offered on the reset edge.
    doReset();
    drive(1'b1, 16'h1111);
    drive(1'b1, 16'h2222);
    rst = 1'b1;
    drive(1'b1, 16'h3333);
    rst = 1'b0;
    drive(1'b1, 16'h6261);
    drive(1'b1, 16'h6463);
    drive(1'b1, 16'h0065);
    drive(1'b0, 16'h0);
    check("midrst_A", ifA.dout, 32'hF04FC729);
    check("midrst_B", ifB.dout, 32'hF04FC729);

    // Random streams with random idle gaps against the reference model.
    for (int t = 0; t < 30; t++) begin
      int unsigned len;
      logic [15:0] w;
      doReset();
      len = $urandom_range(1, 40);
      for (int i = 0; i < int'(len); i++) begin
        w = randWord();
        words.push_back(w);
        drive(1'b1, w);
        if ($urandom_range(0, 3) == 0) drive(1'b0, 16'($urandom()));
      end
      drive(1'b0, 16'h0);
      check($sformatf("rand%0d_A", t), ifA.dout, refSum(words, 16));
      check($sformatf("rand%0d_B", t), ifB.dout, refSum(words, 16));
      check($sformatf("rand%0d_C", t), {16'h0, ifC.dout}, refSum(words, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
